// File: rtl/stack_exec_unit.sv
// stack_exec_unit
// Command-driven stack execution engine: internal operand stack, an ALU
// (ADD/SUB with flags) and a handshaked data-memory port for PUSH_MEM/POP_MEM.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_op, cmd_data      opcode and immediate/address
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata, mem_ack
//                         data-memory request port, requests held until ack
//   top, depth            current top of stack (0 when empty), entry count
//   flags                 {overflow, carry, negative, zero}, written by ADD/SUB
//   error                 sticky precondition fault, cleared only by reset
//
// Optional build macro STACK_PEEK_EN adds peek_index/peek_data, a
// combinational side-effect-free read of the entry peek_index below top.

module stack_exec_unit #(
    parameter int WORD_RANGE       = 8,
    parameter int STACK_WORD_COUNT = 8,
    parameter int ADDR_RANGE       = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [2:0]                            cmd_op,
    input  logic [WORD_RANGE-1:0]                 cmd_data,
    output logic [ADDR_RANGE-1:0]                 mem_addr,
    output logic                                  mem_rd,
    output logic                                  mem_wr,
    output logic [WORD_RANGE-1:0]                 mem_wdata,
    input  logic [WORD_RANGE-1:0]                 mem_rdata,
    input  logic                                  mem_ack,
    output logic [WORD_RANGE-1:0]                 top,
    output logic [$clog2(STACK_WORD_COUNT+1)-1:0] depth,
    output logic [3:0]                            flags,
    output logic                                  error
`ifdef STACK_PEEK_EN
    ,
    input  logic [$clog2(STACK_WORD_COUNT)-1:0]   peek_index,
    output logic [WORD_RANGE-1:0]                 peek_data
`endif
);

    localparam int DW = $clog2(STACK_WORD_COUNT + 1);
    localparam int IW = $clog2(STACK_WORD_COUNT);
    localparam logic [DW-1:0] FULL = DW'(STACK_WORD_COUNT);

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH_IMM = 3'd1,
        OP_PUSH_MEM = 3'd2,
        OP_POP_MEM  = 3'd3,
        OP_ADD      = 3'd4,
        OP_SUB      = 3'd5,
        OP_DUP      = 3'd6,
        OP_DROP     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_MEM_WR = 2'd2
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    op_e                    w_op;
    logic [WORD_RANGE-1:0]  r_stack [STACK_WORD_COUNT];
    logic [DW-1:0]          r_depth;
    logic [3:0]             r_flags;
    logic                   r_error;
    logic [ADDR_RANGE-1:0]  r_mem_addr;
    logic [WORD_RANGE-1:0]  r_mem_wdata;

    logic [IW-1:0]          w_push_idx;
    logic [IW-1:0]          w_top_idx;
    logic [IW-1:0]          w_nos_idx;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_two;
    logic [WORD_RANGE-1:0]  w_top;
    logic [WORD_RANGE-1:0]  w_nos;
    logic                   w_accept;
    logic                   w_illegal;
    logic                   w_exec;
    logic [ADDR_RANGE-1:0]  w_cmd_addr;
    logic [WORD_RANGE:0]    w_sum;
    logic [WORD_RANGE:0]    w_diff;
    logic [WORD_RANGE-1:0]  w_result;
    logic                   w_carry;
    logic                   w_ovf;

    assign w_op       = op_e'(cmd_op);
    assign w_cmd_addr = ADDR_RANGE'(cmd_data);

    // Entry 0 is the bottom; index depth is the next free slot.
    assign w_push_idx = IW'(r_depth);
    assign w_top_idx  = IW'(r_depth - DW'(1));
    assign w_nos_idx  = IW'(r_depth - DW'(2));
    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == FULL);
    assign w_two      = (r_depth >= DW'(2));
    assign w_top      = w_empty ? '0 : r_stack[w_top_idx];
    assign w_nos      = r_stack[w_nos_idx];

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_exec     = w_accept && !w_illegal;

    always_comb begin
        w_illegal = 1'b0;
        case (w_op)
            OP_PUSH_IMM, OP_PUSH_MEM: w_illegal = w_full;
            OP_DUP:                   w_illegal = w_full || w_empty;
            OP_POP_MEM, OP_DROP:      w_illegal = w_empty;
            OP_ADD, OP_SUB:           w_illegal = !w_two;
            default:                  w_illegal = 1'b0;
        endcase
    end

    // a = next-on-stack, b = top
    assign w_sum  = {1'b0, w_nos} + {1'b0, w_top};
    assign w_diff = {1'b0, w_nos} - {1'b0, w_top};

    always_comb begin
        w_result = w_sum[WORD_RANGE-1:0];
        w_carry  = w_sum[WORD_RANGE];
        w_ovf    = (w_nos[WORD_RANGE-1] == w_top[WORD_RANGE-1]) &&
                   (w_sum[WORD_RANGE-1] != w_nos[WORD_RANGE-1]);
        if (w_op == OP_SUB) begin
            w_result = w_diff[WORD_RANGE-1:0];
            w_carry  = w_diff[WORD_RANGE];   // borrow out
            w_ovf    = (w_nos[WORD_RANGE-1] != w_top[WORD_RANGE-1]) &&
                       (w_diff[WORD_RANGE-1] != w_nos[WORD_RANGE-1]);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_exec && (w_op == OP_PUSH_MEM))     w_state_next = ST_MEM_RD;
                else if (w_exec && (w_op == OP_POP_MEM)) w_state_next = ST_MEM_WR;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ack) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        mem_rd    = (r_state == ST_MEM_RD);
        mem_wr    = (r_state == ST_MEM_WR);
    end

    // Datapath. Memory completions only happen outside IDLE, so they never
    // collide with a command executing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_depth     <= '0;
            r_flags     <= '0;
            r_error     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int unsigned i = 0; i < STACK_WORD_COUNT; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            if (w_accept && w_illegal) r_error <= 1'b1;
            if (w_exec) begin
                case (w_op)
                    OP_PUSH_IMM: begin
                        r_stack[w_push_idx] <= cmd_data;
                        r_depth             <= r_depth + DW'(1);
                    end
                    OP_DUP: begin
                        r_stack[w_push_idx] <= w_top;
                        r_depth             <= r_depth + DW'(1);
                    end
                    OP_DROP: r_depth <= r_depth - DW'(1);
                    OP_ADD, OP_SUB: begin
                        r_stack[w_nos_idx] <= w_result;
                        r_depth            <= r_depth - DW'(1);
                        r_flags            <= {w_ovf, w_carry, w_result[WORD_RANGE-1],
                                               (w_result == '0)};
                    end
                    OP_PUSH_MEM: r_mem_addr <= w_cmd_addr;
                    OP_POP_MEM: begin
                        r_mem_addr  <= w_cmd_addr;
                        r_mem_wdata <= w_top;
                    end
                    default: ;
                endcase
            end
            if ((r_state == ST_MEM_RD) && mem_ack) begin
                r_stack[w_push_idx] <= mem_rdata;
                r_depth             <= r_depth + DW'(1);
            end
            if ((r_state == ST_MEM_WR) && mem_ack) begin
                r_depth <= r_depth - DW'(1);
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign top       = w_top;
    assign depth     = r_depth;
    assign flags     = r_flags;
    assign error     = r_error;

`ifdef STACK_PEEK_EN
    always_comb begin
        peek_data = '0;
        if (DW'(peek_index) < r_depth) begin
            peek_data = r_stack[IW'(r_depth - DW'(1) - DW'(peek_index))];
        end
    end
`endif

endmodule

// File: doc/stack_exec_unit.md
Name: stack_exec_unit

Overview:
- Parametrised successor to the stack-machine datapath: a command-driven stack execution engine with an internal operand stack, an ALU and a handshaked data-memory port.
- Accepts one command per valid/ready handshake and runs push, pop, arithmetic and memory load/store through a small FSM.
- Reports status flags, stack depth and a sticky error.
- Sits between the control unit (command source) and data memory.

Parameters:
- WORD_RANGE, 8, data word width in bits.
- STACK_WORD_COUNT, 8, stack depth in words; must be ≥2.
- ADDR_RANGE, 8, data-memory address width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  unit can accept a command.
- cmd_op  input  3  opcode: 0 NOP, 1 PUSH_IMM, 2 PUSH_MEM, 3 POP_MEM, 4 ADD, 5 SUB, 6 DUP, 7 DROP.
- cmd_data  input  WORD_RANGE  immediate value (PUSH_IMM) or address (low ADDR_RANGE bits, for PUSH_MEM/POP_MEM).
- mem_addr  output  ADDR_RANGE  data-memory address.
- mem_rd  output  1  read request, held until acknowledged.
- mem_wr  output  1  write request, held until acknowledged.
- mem_wdata  output  WORD_RANGE  write data.
- mem_rdata  input  WORD_RANGE  read data, valid when mem_ack=1.
- mem_ack  input  1  memory completes the current request.
- top  output  WORD_RANGE  current top of stack; 0 when the stack is empty.
- depth  output  $clog2(STACK_WORD_COUNT+1)  number of valid entries.
- flags  output  4  {overflow, carry, negative, zero}.
- error  output  1  sticky fault flag.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; depth=0; top=0; flags=0; error=0; mem_rd=mem_wr=0; mem_addr=0; mem_wdata=0.
- Reset mid-transaction aborts it immediately; no stack write occurs.
- FSM states: IDLE, MEM_RD, MEM_WR. cmd_ready=1 only in IDLE. A command is accepted on an edge where cmd_valid & cmd_ready.
- Single-cycle ops (NOP, PUSH_IMM, ADD, SUB, DUP, DROP) complete on the accepting edge. The FSM stays in IDLE, so back-to-back commands sustain one per cycle.
- PUSH_IMM: push cmd_data.
- DUP: push a copy of top.
- DROP: remove the top entry.
- ADD/SUB: b=pop, a=pop, push a+b or a−b (mod 2^WORD_RANGE); net depth change −1.
- Flags are updated only by ADD and SUB:
  - zero: result==0.
  - negative: result MSB.
  - carry: carry-out for ADD; borrow (a<b unsigned) for SUB.
  - overflow: signed two's-complement overflow.
- PUSH_MEM: on accept, go to MEM_RD with mem_addr=cmd_data and mem_rd=1 from the next cycle. The first edge with mem_ack=1 pushes mem_rdata, drops mem_rd and returns to IDLE. Minimum latency is 2 cycles (ack in the first MEM_RD cycle).
- POP_MEM: on accept, go to MEM_WR with mem_addr=cmd_data, mem_wdata=top and mem_wr=1. The stack entry is popped on the ack edge, then return to IDLE.
- mem_ack outside MEM_RD/MEM_WR is ignored. mem_rd and mem_wr are never asserted together.
- Preconditions, checked at accept:
  - Pushing ops (PUSH_IMM, PUSH_MEM, DUP) need depth<STACK_WORD_COUNT.
  - Pops need depth≥1 (DROP, POP_MEM, DUP) or depth≥2 (ADD, SUB).
- A violated precondition makes the command a NOP: stack, flags and memory are untouched, no memory request is issued, and error is set. The command is still consumed.
- error clears only on reset.
- Boundary cases:
  - Full-stack PUSH_IMM → error, depth stays STACK_WORD_COUNT.
  - Empty-stack DROP → error, depth stays 0.
  - Invalid commands trigger no memory access.

Optional Feature:
- Macro: STACK_PEEK_EN.
- Defined: adds input peek_index [$clog2(STACK_WORD_COUNT)-1:0] and output peek_data [WORD_RANGE-1:0].
  - peek_data is a combinational read of the entry peek_index positions below top (0 = top).
  - peek_data=0 when peek_index≥depth.
  - Peeking has no side effects.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- Reset, then PUSH_IMM 0x05, PUSH_IMM 0x03, ADD → top=0x08, depth=1, flags=0000, error=0; cmd_ready high every cycle.
- PUSH_IMM 0x03, PUSH_IMM 0x05, SUB → top=0xFE, negative=1, carry=1, zero=0; then PUSH_IMM 0x7F, PUSH_IMM 0x01, ADD → top=0x80, overflow=1.
- PUSH_MEM addr 0x10 with memory model acking after 3 cycles and returning 0xA5 → mem_rd high with mem_addr=0x10 until ack; cmd_ready low meanwhile; afterwards top=0xA5, depth+1.
- Fill with 8 PUSH_IMM (STACK_WORD_COUNT=8), then a 9th → depth=8, error=1, top unchanged; POP_MEM addr 0x20 → mem_wr with mem_wdata=last pushed value, depth=7 after ack.
- Empty stack: ADD and DROP → error=1, depth=0, mem_rd=mem_wr=0; pulse reset_n low during a pending POP_MEM → mem_wr drops immediately, depth=0, error=0.
- With STACK_PEEK_EN: push 0x11, 0x22, 0x33; peek_index=0/1/2/3 → 0x33/0x22/0x11/0x00.
